key_step_pulser: RTL and testbench

//  Conditions the raw, bouncy, active-low step pushbutton (KEY[0]) into a clean
//  one-cycle step pulse in the CLOCK_50 domain. It sits directly upstream of the

---
 rtl/key_step_pulser.sv | 118 +++++++++++
 tb/tb_key_step_pulser.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_step_pulser.sv
// Debounces the active-low step pushbutton into a one-cycle step pulse,
// plus the debounced key level, a wrapping press counter and a busy flag.
module key_step_pulser #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       key_n,
  output logic       step_pulse,
  output logic       key_level,
  output logic       busy,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_pulse_q, step_pulse_d;
  logic             key_level_q, key_level_d;
  logic             busy_q, busy_d;
  logic [7:0]       press_count_q, press_count_d;

  // Two-flop synchroniser; both stages reset to "released" so reset never fakes a press.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here let s2_q take the old s1_q, forming a real two-stage chain.
      s1_q <= key_n;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    step_pulse_d  = 1'b0;
    key_level_d   = key_level_q;
    press_count_d = press_count_q;

    case (state_q)
      RELEASED: begin
        if (!s2_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (s2_q) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          step_pulse_d  = 1'b1;
          key_level_d   = 1'b1;
          press_count_d = press_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (s2_q) begin
          state_d = WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (!s2_q) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RELEASED;
          key_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase

    // Registered from the next state so busy lines up exactly with the qualifying states.
    busy_d = (state_d == WAIT_PRESS) || (state_d == WAIT_RELEASE);
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= RELEASED;
      cnt_q         <= '0;
      step_pulse_q  <= 1'b0;
      key_level_q   <= 1'b0;
      busy_q        <= 1'b0;
      press_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      step_pulse_q  <= step_pulse_d;
      key_level_q   <= key_level_d;
      busy_q        <= busy_d;
      press_count_q <= press_count_d;
    end
  end

  assign step_pulse  = step_pulse_q;
  assign key_level   = key_level_q;
  assign busy        = busy_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_key_step_pulser.sv
// Directed bench for key_step_pulser with DEBOUNCE_CYCLES=4 and a 10 ns clock.
module tb_key_step_pulser;

  logic       clock;
  logic       resetb;
  logic       key_n;
  logic       step_pulse;
  logic       key_level;
  logic       busy;
  logic [7:0] press_count;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  int busy_seen = 0;

  key_step_pulser #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .clock      (clock),
    .resetb     (resetb),
    .key_n      (key_n),
    .step_pulse (step_pulse),
    .key_level  (key_level),
    .busy       (busy),
    .press_count(press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (step_pulse) pulse_cnt++;
    if (busy) busy_seen++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges and sample 1 ns after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_pulse"}, 32'(step_pulse), 0);
    check({tag, "_level"}, 32'(key_level), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_count"}, 32'(press_count), 0);
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clock);
    resetb = 1'b0;
    repeat (cycles) @(negedge clock);
    resetb = 1'b1;
  endtask

  task automatic clean_press(input int hold);
    @(negedge clock);
    key_n = 1'b0;
    repeat (hold) @(negedge clock);
    key_n = 1'b1;
    repeat (hold) @(negedge clock);
  endtask

  initial begin
    int base;
    int timeout;

    resetb = 1'b0;
    key_n  = 1'b1;

    // 1: reset with the key toggling
    repeat (5) begin
      @(negedge clock);
      key_n = ~key_n;
      #1;
      check_idle_outputs("reset");
    end
    @(negedge clock);
    key_n  = 1'b1;
    resetb = 1'b1;
    tick(3);
    check_idle_outputs("post_reset");

    // 2: clean press, pulse on edge 7 after the first low sample
    base = pulse_cnt;
    @(negedge clock);
    key_n = 1'b0;
    tick(3);
    check("press_busy_e3", 32'(busy), 1);
    tick(3);
    check("press_pulse_e6", 32'(step_pulse), 0);
    check("press_level_e6", 32'(key_level), 0);
    tick(1);
    check("press_pulse_e7", 32'(step_pulse), 1);
    check("press_level_e7", 32'(key_level), 1);
    check("press_count_e7", 32'(press_count), 1);
    check("press_busy_e7", 32'(busy), 0);
    tick(1);
    check("press_pulse_e8", 32'(step_pulse), 0);
    repeat (12) @(negedge clock);
    key_n = 1'b1;
    tick(6);
    check("release_level_e6", 32'(key_level), 1);
    tick(1);
    check("release_level_e7", 32'(key_level), 0);
    repeat (12) @(negedge clock);
    check("press_pulses", pulse_cnt - base, 1);
    check("release_count", 32'(press_count), 1);

    // 3: bounce, toggle every 2 cycles for 40 cycles
    base      = pulse_cnt;
    busy_seen = 0;
    key_n     = 1'b0;
    repeat (20) begin
      repeat (2) @(negedge clock);
      key_n = ~key_n;
    end
    key_n = 1'b1;
    tick(10);
    check("bounce_pulses", pulse_cnt - base, 0);
    check("bounce_count", 32'(press_count), 1);
    check("bounce_busy_seen", 32'(busy_seen != 0), 1);
    check("bounce_level", 32'(key_level), 0);
    check("bounce_busy_end", 32'(busy), 0);

    // 4: one-cycle release glitch while held
    base = pulse_cnt;
    @(negedge clock);
    key_n = 1'b0;
    repeat (12) @(negedge clock);
    check("glitch_pre_level", 32'(key_level), 1);
    key_n = 1'b1;
    @(negedge clock);
    key_n = 1'b0;
    tick(15);
    check("glitch_level", 32'(key_level), 1);
    check("glitch_pulses", pulse_cnt - base, 1);
    check("glitch_count", 32'(press_count), 2);
    @(negedge clock);
    key_n = 1'b1;
    tick(15);
    check("glitch_release_level", 32'(key_level), 0);

    // 5: wrap after 256 presses from reset
    apply_reset(2);
    tick(1);
    check("wrap_reset_count", 32'(press_count), 0);
    base = pulse_cnt;
    repeat (255) clean_press(12);
    check("wrap_count_255", 32'(press_count), 255);
    clean_press(12);
    check("wrap_count_0", 32'(press_count), 0);
    check("wrap_pulses", pulse_cnt - base, 256);

    // 6: reset during WAIT_PRESS, key still held after release
    base = pulse_cnt;
    @(negedge clock);
    key_n   = 1'b0;
    timeout = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (busy) begin
        timeout = 0;
        break;
      end
    end
    check("abort_busy_timeout", 32'(timeout), 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetb = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check_idle_outputs("abort_reset");
    check("abort_pulses", pulse_cnt - base, 0);
    @(negedge clock);
    resetb = 1'b1;
    tick(6);
    check("abort_pulse_e6", 32'(step_pulse), 0);
    tick(1);
    check("abort_pulse_e7", 32'(step_pulse), 1);
    check("abort_count_e7", 32'(press_count), 1);
    tick(20);
    check("abort_held_pulses", pulse_cnt - base, 1);
    check("abort_held_level", 32'(key_level), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
